sram_rr_arbiter_64x512: RTL

SRAM_RR_ARBITER_64X512 -- requirements
Module: sram_rr_arbiter_64x512

---
 rtl/sram_rr_arbiter_64x512.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/sram_rr_arbiter_64x512.sv
// Two-port round-robin front end for a single-port SRAM macro: optional zero-fill
// after reset, one grant per cycle, and a tagged two-edge read response pipeline.
module sram_rr_arbiter_64x512 #(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter bit          INIT_EN    = 1'b1
) (
  input  logic                  clk0,
  input  logic                  rst0,

  input  logic                  p0_valid,
  output logic                  p0_ready,
  input  logic                  p0_we,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  output logic                  p0_rsp_valid,
  output logic [DATA_WIDTH-1:0] p0_rsp_rdata,

  input  logic                  p1_valid,
  output logic                  p1_ready,
  input  logic                  p1_we,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p1_rsp_valid,
  output logic [DATA_WIDTH-1:0] p1_rsp_rdata,

  output logic                  init_done,

  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
);

  localparam int unsigned RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic                  ptr;
  logic                  active;
  logic                  gnt0;
  logic                  gnt1;
  logic                  rd_issue;
  logic                  rd_pend;
  logic                  rd_tag;

  // State register
  always_ff @(posedge clk0) begin
    if (rst0) begin
      if (INIT_EN) state <= ST_INIT;
      else         state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next state: leave INIT once the last address has been written
  always_comb begin
    state_next = state;
    case (state)
      ST_INIT: if (init_cnt == LAST_ADDR) state_next = ST_RUN;
      ST_RUN:  state_next = ST_RUN;
    endcase
  end

  // Zero-fill address counter
  always_ff @(posedge clk0) begin
    if (rst0) begin
      init_cnt <= '0;
    end else if (state == ST_INIT) begin
      init_cnt <= init_cnt + ADDR_WIDTH'(1);
    end
  end

  // Arbitration: a lone requester always wins, a tie goes to the pointer port
  always_comb begin
    active = (state == ST_RUN) && !rst0;
    gnt0   = active && p0_valid && (!p1_valid || !ptr);
    gnt1   = active && p1_valid && (!p0_valid ||  ptr);
  end

  // Outputs: handshake and macro control, idle (deselected) by default
  always_comb begin
    p0_ready   = 1'b0;
    p1_ready   = 1'b0;
    sram_csb0  = 1'b1;
    sram_web0  = 1'b1;
    sram_addr0 = '0;
    sram_din0  = '0;
    if (!rst0) begin
      case (state)
        ST_INIT: begin
          sram_csb0  = 1'b0;
          sram_web0  = 1'b0;
          sram_addr0 = init_cnt;
        end
        ST_RUN: begin
          p0_ready = gnt0;
          p1_ready = gnt1;
          if (gnt0) begin
            sram_csb0  = 1'b0;
            sram_web0  = ~p0_we;
            sram_addr0 = p0_addr;
            sram_din0  = p0_wdata;
          end else if (gnt1) begin
            sram_csb0  = 1'b0;
            sram_web0  = ~p1_we;
            sram_addr0 = p1_addr;
            sram_din0  = p1_wdata;
          end
        end
      endcase
    end
  end

  // Round-robin pointer hands priority to the port that lost
  always_ff @(posedge clk0) begin
    if (rst0) begin
      ptr <= 1'b0;
    end else if (gnt0) begin
      ptr <= 1'b1;
    end else if (gnt1) begin
      ptr <= 1'b0;
    end
  end

  assign rd_issue = (gnt0 && !p0_we) || (gnt1 && !p1_we);

  // Stage 1: macro is reading; remember whether it was a read and for whom
  always_ff @(posedge clk0) begin
    if (rst0) begin
      rd_pend <= 1'b0;
      rd_tag  <= 1'b0;
    end else begin
      rd_pend <= rd_issue;
      rd_tag  <= gnt1;
    end
  end

  // Stage 2: capture macro output and strobe the owning port
  always_ff @(posedge clk0) begin
    if (rst0) begin
      p0_rsp_valid <= 1'b0;
      p1_rsp_valid <= 1'b0;
      p0_rsp_rdata <= '0;
      p1_rsp_rdata <= '0;
    end else begin
      p0_rsp_valid <= rd_pend && !rd_tag;
      p1_rsp_valid <= rd_pend &&  rd_tag;
      if (rd_pend && !rd_tag) p0_rsp_rdata <= sram_dout0;
      if (rd_pend &&  rd_tag) p1_rsp_rdata <= sram_dout0;
    end
  end

  // init_done rises the cycle after RUN is entered
  always_ff @(posedge clk0) begin
    if (rst0) begin
      init_done <= !INIT_EN;
    end else if (state == ST_RUN) begin
      init_done <= 1'b1;
    end
  end

endmodule
